// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core.
// Optional feature macro used by the core: UART_LOOPBACK_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP1,
    TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [3:0] MIN_LEN = 4'd5;

  // Character length forced into the range the datapath supports
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] maxLen);
    if (len < MIN_LEN) return MIN_LEN;
    else if (len > maxLen) return maxLen;
    else return len;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every max(baud_div,1) clocks.
// Part of the UART core; the core's optional macro is UART_LOOPBACK_EN (unused here).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [DIV_W-1:0] i_baud_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] w_last;

  // A divisor of zero behaves like one; >= keeps a shrinking divisor from overrunning
  assign w_last = (i_baud_div == '0) ? '0 : i_baud_div - DIV_W'(1);
  assign o_tick = !i_rst && (r_count >= w_last);

  // Free-running counter that wraps on the tick
  always_ff @(posedge i_clk) begin
    if (i_rst) r_count <= '0;
    else if (r_count >= w_last) r_count <= '0;
    else r_count <= r_count + DIV_W'(1);
  end

endmodule

// File: rtl/uart_core_param.sv
// Single-clock UART transceiver with shared oversample tick, runtime framing
// and independent TX/RX state machines.
// Optional feature macro: UART_LOOPBACK_EN (adds i_loopback, routes TX into RX).
module uart_core_param
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int DIV_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DIV_W-1:0]  i_baud_div,
  input  logic [3:0]        i_length,
  input  logic              i_parity_en,
  input  logic              i_parity_type,
  input  logic              i_stop2,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_tx_done,
  output logic              o_txd,
  input  logic              i_rxd,
  output logic              o_rx_valid,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_parity_err,
  output logic              o_rx_frame_err
`ifdef UART_LOOPBACK_EN
  ,
  input  logic              i_loopback
`endif
);

  localparam int CNT_W = $clog2(OVS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2 - 1);

  logic w_tick;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_baud_div (i_baud_div),
    .o_tick     (w_tick)
  );

  // ---------------- transmitter ----------------
  tx_state_t         r_txState, w_txNext;
  logic              r_txPend;
  logic [CNT_W-1:0]  r_txCnt;
  logic [3:0]        r_txIdx, r_txLen;
  logic [DATA_W-1:0] r_txShift;
  logic              r_txParEn, r_txParBit, r_txStop2, r_txDone;
  logic              w_txSerial, w_txAccept, w_txBitEnd, w_txLastStop, w_txParIn;
  logic [3:0]        w_txLenIn;
  logic [DATA_W-1:0] w_txMask;

  assign w_txLenIn    = clamp_len(i_length, 4'(DATA_W));
  assign w_txMask     = (DATA_W'(1) << w_txLenIn) - DATA_W'(1);
  assign w_txParIn    = (^(i_tx_data & w_txMask)) ^ (i_parity_type == PAR_ODD);
  assign w_txAccept   = i_tx_valid && o_tx_ready;
  assign w_txBitEnd   = w_tick && (r_txCnt == CNT_LAST);
  assign w_txLastStop = (r_txState == TX_STOP2) || (r_txState == TX_STOP1 && !r_txStop2);
  assign o_tx_done    = r_txDone;

  // TX state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_txState <= TX_IDLE;
    else r_txState <= w_txNext;
  end

  // TX next state: each bit lasts OVS ticks, framing taken from the latched config
  always_comb begin
    w_txNext = r_txState;
    case (r_txState)
      TX_IDLE:   if (r_txPend && w_tick) w_txNext = TX_START;
      TX_START:  if (w_txBitEnd) w_txNext = TX_DATA;
      TX_DATA:   if (w_txBitEnd && r_txIdx == r_txLen - 4'd1)
                   w_txNext = r_txParEn ? TX_PARITY : TX_STOP1;
      TX_PARITY: if (w_txBitEnd) w_txNext = TX_STOP1;
      TX_STOP1:  if (w_txBitEnd) w_txNext = r_txStop2 ? TX_STOP2 : TX_IDLE;
      TX_STOP2:  if (w_txBitEnd) w_txNext = TX_IDLE;
      default:   w_txNext = TX_IDLE;
    endcase
  end

  // TX outputs: ready only when idle with nothing waiting for the first tick
  always_comb begin
    o_tx_ready = (r_txState == TX_IDLE) && !r_txPend;
    w_txSerial = 1'b1;
    case (r_txState)
      TX_START:  w_txSerial = 1'b0;
      TX_DATA:   w_txSerial = r_txShift[0];
      TX_PARITY: w_txSerial = r_txParBit;
      default:   w_txSerial = 1'b1;
    endcase
  end

  // TX datapath: latch character and config on accept, count ticks, shift bits out
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_txPend   <= 1'b0;
      r_txCnt    <= '0;
      r_txIdx    <= '0;
      r_txLen    <= MIN_LEN;
      r_txShift  <= '0;
      r_txParEn  <= 1'b0;
      r_txParBit <= 1'b0;
      r_txStop2  <= 1'b0;
      r_txDone   <= 1'b0;
    end else begin
      r_txDone <= w_txBitEnd && w_txLastStop;
      if (w_txAccept) begin
        r_txPend   <= 1'b1;
        r_txShift  <= i_tx_data;
        r_txLen    <= w_txLenIn;
        r_txParEn  <= i_parity_en;
        r_txParBit <= w_txParIn;
        r_txStop2  <= i_stop2;
      end else if (r_txState == TX_IDLE && r_txPend && w_tick) begin
        r_txPend <= 1'b0;
      end
      if (r_txState == TX_IDLE) r_txCnt <= '0;
      else if (w_tick) r_txCnt <= (r_txCnt == CNT_LAST) ? '0 : r_txCnt + CNT_W'(1);
      if (r_txState != TX_DATA) r_txIdx <= '0;
      else if (w_txBitEnd) begin
        r_txIdx   <= r_txIdx + 4'd1;
        r_txShift <= r_txShift >> 1;
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t         r_rxState, w_rxNext;
  logic              r_sync1, r_sync2, w_rxIn;
  logic [CNT_W-1:0]  r_rxCnt;
  logic [3:0]        r_rxIdx, r_rxLen;
  logic [DATA_W-1:0] r_rxShift, r_rxData;
  logic              r_rxParEn, r_rxParType, r_rxStop2;
  logic              r_rxPeAcc, r_rxFeAcc, r_rxArmed;
  logic              r_rxValid, r_rxPe, r_rxFe;
  logic              w_rxStartDet, w_rxSample, w_rxLastStop, w_rxFinal, w_rxFeFinal;

`ifdef UART_LOOPBACK_EN
  assign w_rxIn = i_loopback ? w_txSerial : i_rxd;
  assign o_txd  = i_loopback ? 1'b1 : w_txSerial;
`else
  assign w_rxIn = i_rxd;
  assign o_txd  = w_txSerial;
`endif

  assign o_rx_valid      = r_rxValid;
  assign o_rx_data       = r_rxData;
  assign o_rx_parity_err = r_rxPe;
  assign o_rx_frame_err  = r_rxFe;

  // RX state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_rxState <= RX_IDLE;
    else r_rxState <= w_rxNext;
  end

  // RX sample strobes: half a bit after start detect, then every OVS ticks
  always_comb begin
    w_rxStartDet = (r_rxState == RX_IDLE) && w_tick && !r_sync2 && r_rxArmed;
    w_rxSample   = w_tick && (((r_rxState == RX_START) && (r_rxCnt == CNT_HALF)) ||
                              ((r_rxState != RX_IDLE) && (r_rxState != RX_START) &&
                               (r_rxCnt == CNT_LAST)));
    w_rxLastStop = (r_rxState == RX_STOP2) || (r_rxState == RX_STOP1 && !r_rxStop2);
    w_rxFinal    = w_rxSample && w_rxLastStop;
    w_rxFeFinal  = r_rxFeAcc || !r_sync2;
  end

  // RX next state: a start bit that reads high at mid-bit is treated as a glitch
  always_comb begin
    w_rxNext = r_rxState;
    case (r_rxState)
      RX_IDLE:   if (w_rxStartDet) w_rxNext = RX_START;
      RX_START:  if (w_rxSample) w_rxNext = r_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_rxSample && r_rxIdx == r_rxLen - 4'd1)
                   w_rxNext = r_rxParEn ? RX_PARITY : RX_STOP1;
      RX_PARITY: if (w_rxSample) w_rxNext = RX_STOP1;
      RX_STOP1:  if (w_rxSample) w_rxNext = r_rxStop2 ? RX_STOP2 : RX_IDLE;
      RX_STOP2:  if (w_rxSample) w_rxNext = RX_IDLE;
      default:   w_rxNext = RX_IDLE;
    endcase
  end

  // RX datapath: synchroniser, tick counting, bit capture, error accumulation, result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_rxCnt     <= '0;
      r_rxIdx     <= '0;
      r_rxLen     <= MIN_LEN;
      r_rxShift   <= '0;
      r_rxParEn   <= 1'b0;
      r_rxParType <= PAR_EVEN;
      r_rxStop2   <= 1'b0;
      r_rxPeAcc   <= 1'b0;
      r_rxFeAcc   <= 1'b0;
      r_rxArmed   <= 1'b1;
      r_rxValid   <= 1'b0;
      r_rxData    <= '0;
      r_rxPe      <= 1'b0;
      r_rxFe      <= 1'b0;
    end else begin
      r_sync1   <= w_rxIn;
      r_sync2   <= r_sync1;
      r_rxValid <= 1'b0;
      if (r_rxState == RX_IDLE && !r_rxArmed && r_sync2) r_rxArmed <= 1'b1;
      if (w_rxStartDet) begin
        r_rxCnt     <= '0;
        r_rxIdx     <= '0;
        r_rxShift   <= '0;
        r_rxLen     <= clamp_len(i_length, 4'(DATA_W));
        r_rxParEn   <= i_parity_en;
        r_rxParType <= i_parity_type;
        r_rxStop2   <= i_stop2;
        r_rxPeAcc   <= 1'b0;
        r_rxFeAcc   <= 1'b0;
      end else if (r_rxState != RX_IDLE && w_tick) begin
        r_rxCnt <= w_rxSample ? '0 : r_rxCnt + CNT_W'(1);
      end
      if (w_rxSample) begin
        case (r_rxState)
          RX_DATA: begin
            r_rxShift <= r_rxShift | (DATA_W'(r_sync2) << r_rxIdx);
            r_rxIdx   <= r_rxIdx + 4'd1;
          end
          RX_PARITY: r_rxPeAcc <= (r_sync2 != ((^r_rxShift) ^ (r_rxParType == PAR_ODD)));
          RX_STOP1, RX_STOP2: if (!r_sync2) r_rxFeAcc <= 1'b1;
          default: ;
        endcase
      end
      if (w_rxFinal) begin
        r_rxValid <= 1'b1;
        r_rxData  <= r_rxShift;
        r_rxPe    <= r_rxPeAcc;
        r_rxFe    <= w_rxFeFinal;
        if (w_rxFeFinal) r_rxArmed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Self-checking bench for uart_core_param: directed framing cases plus randomized
// TX and RX frames compared against a frame-level reference model.
// Honours the optional macro UART_LOOPBACK_EN when the design is built with it.
module tb_uart_core_param;

  localparam int DATA_W = 8;
  localparam int OVS    = 16;
  localparam int DIV_W  = 16;

  logic              clk, rst;
  logic [DIV_W-1:0]  baudDiv;
  logic [3:0]        length;
  logic              parityEn, parityType, stop2;
  logic              txValid, txReady, txDone, txd;
  logic [DATA_W-1:0] txData;
  logic              rxd, rxdDrv, tieLoop;
  logic              rxValid, rxParityErr, rxFrameErr;
  logic [DATA_W-1:0] rxData;
`ifdef UART_LOOPBACK_EN
  logic              loopback;
`endif

  int testsRun, testsFailed;
  int rxCount, txDoneCount;
  logic [DATA_W-1:0] rxLastData;
  logic rxLastPe, rxLastFe;
  int effDiv;
  bit trace  [0:1023];
  bit doneTr [0:1023];

  assign rxd = tieLoop ? txd : rxdDrv;

  uart_core_param #(.DATA_W(DATA_W), .OVS(OVS), .DIV_W(DIV_W)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_baud_div      (baudDiv),
    .i_length        (length),
    .i_parity_en     (parityEn),
    .i_parity_type   (parityType),
    .i_stop2         (stop2),
    .i_tx_valid      (txValid),
    .o_tx_ready      (txReady),
    .i_tx_data       (txData),
    .o_tx_done       (txDone),
    .o_txd           (txd),
    .i_rxd           (rxd),
    .o_rx_valid      (rxValid),
    .o_rx_data       (rxData),
    .o_rx_parity_err (rxParityErr),
    .o_rx_frame_err  (rxFrameErr)
`ifdef UART_LOOPBACK_EN
    ,
    .i_loopback      (loopback)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every received character and every tx_done pulse
  always @(negedge clk) begin
    if (rxValid) begin
      rxCount    <= rxCount + 1;
      rxLastData <= rxData;
      rxLastPe   <= rxParityErr;
      rxLastFe   <= rxFrameErr;
    end
    if (txDone) txDoneCount <= txDoneCount + 1;
  end

  // Hang guard
  initial begin
    #950000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int clampLen(input int len);
    if (len < 5) return 5;
    if (len > DATA_W) return DATA_W;
    return len;
  endfunction

  function automatic int frameLen(input int len, input int pen, input int st2);
    return 1 + len + pen + 1 + st2;
  endfunction

  // Line levels of a whole frame, first bit on the wire in bit 0
  function automatic logic [15:0] buildFrame(input int data, input int len, input int pen,
                                             input int ptype, input int st2, input int stopMask);
    logic [15:0] f;
    int pos, par;
    f = '0;
    pos = 1;
    par = ptype;
    for (int i = 0; i < len; i++) begin
      f[pos] = 1'((data >> i) & 1);
      par = par ^ ((data >> i) & 1);
      pos++;
    end
    if (pen != 0) begin
      f[pos] = 1'(par);
      pos++;
    end
    f[pos] = ((stopMask & 1) == 0);
    pos++;
    if (st2 != 0) f[pos] = ((stopMask & 2) == 0);
    return f;
  endfunction

  task automatic applyStimulus(input int div, input int len, input int pen, input int ptype, input int st2);
    baudDiv    = DIV_W'(div);
    length     = 4'(len);
    parityEn   = 1'(pen);
    parityType = 1'(ptype);
    stop2      = 1'(st2);
    effDiv     = (div == 0) ? 1 : div;
  endtask

  // Offer one character, trace the line for the whole frame, check bits and timing
  task automatic runTxFrame(input int data, input bit checkLow);
    int len, pen, ptype, st2, p, nb, k, doneIdx, lowLen, rxBefore, mask;
    logic [15:0] exp, obs;
    logic readyMid;
    len = clampLen(int'(length));
    pen = int'(parityEn);
    ptype = int'(parityType);
    st2 = int'(stop2);
    p = OVS * effDiv;
    nb = frameLen(len, pen, st2);
    mask = (1 << len) - 1;
    exp = buildFrame(data, len, pen, ptype, st2, 0);
    rxBefore = rxCount;
    readyMid = 1'b1;
    @(negedge clk);
    txData = DATA_W'(data);
    txValid = 1'b1;
    k = 0;
    while (txReady !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    txValid = 1'b0;
    k = 0;
    while (txd !== 1'b0 && k < 4 * p) begin
      @(negedge clk);
      k++;
    end
    if (k >= 4 * p) begin
      checkOutput("txStartSeen", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < nb * p + 4; i++) begin
      trace[i]  = txd;
      doneTr[i] = txDone;
      if (i == p) readyMid = txReady;
      @(negedge clk);
    end
    obs = '0;
    for (int i = 0; i < nb; i++) obs[i] = trace[i * p + p / 2];
    checkOutput("txFrame", 32'(obs), 32'(exp));
    doneIdx = -1;
    for (int i = nb * p + 3; i >= 0; i--) if (doneTr[i]) doneIdx = i;
    checkOutput("txDoneAt", doneIdx, nb * p);
    checkOutput("txBusyReady", 32'(readyMid), 32'd0);
    if (checkLow) begin
      lowLen = 0;
      while (lowLen < 1024 && trace[lowLen] == 1'b0) lowLen++;
      checkOutput("txStartLen", lowLen, p);
    end
    if (tieLoop) begin
      repeat (p) @(negedge clk);
      checkOutput("loopRxCount", rxCount, rxBefore + 1);
      checkOutput("loopRxData", 32'(rxLastData), data & mask);
      checkOutput("loopRxPe", 32'(rxLastPe), 32'd0);
      checkOutput("loopRxFe", 32'(rxLastFe), 32'd0);
    end
  endtask

  // Drive a frame onto rxd (parity sense and stop bits chosen by the caller) and check the result
  task automatic driveRxFrame(input int data, input int sendPtype, input int stopMask);
    int len, pen, ptype, st2, p, nb, rxBefore, mask, expPe, expFe;
    logic [15:0] f;
    len = clampLen(int'(length));
    pen = int'(parityEn);
    ptype = int'(parityType);
    st2 = int'(stop2);
    p = OVS * effDiv;
    nb = frameLen(len, pen, st2);
    mask = (1 << len) - 1;
    f = buildFrame(data, len, pen, sendPtype, st2, stopMask);
    expPe = (pen != 0 && sendPtype != ptype) ? 1 : 0;
    expFe = ((stopMask & 1) != 0 || (st2 != 0 && (stopMask & 2) != 0)) ? 1 : 0;
    rxBefore = rxCount;
    for (int i = 0; i < nb; i++) begin
      rxdDrv = f[i];
      repeat (p) @(negedge clk);
    end
    rxdDrv = 1'b1;
    repeat (2 * p) @(negedge clk);
    checkOutput("rxCount", rxCount, rxBefore + 1);
    checkOutput("rxData", 32'(rxLastData), data & mask);
    checkOutput("rxParityErr", 32'(rxLastPe), expPe);
    checkOutput("rxFrameErr", 32'(rxLastFe), expFe);
  endtask

  initial begin
    int doneBefore, rxBefore, lows;
    testsRun = 0;
    testsFailed = 0;
    rxCount = 0;
    txDoneCount = 0;
    rxLastData = '0;
    rxLastPe = 1'b0;
    rxLastFe = 1'b0;
    rst = 1'b1;
    txValid = 1'b0;
    txData = '0;
    rxdDrv = 1'b1;
    tieLoop = 1'b1;
`ifdef UART_LOOPBACK_EN
    loopback = 1'b0;
`endif
    applyStimulus(2, 8, 0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("rstTxd", 32'(txd), 32'd1);
    checkOutput("rstTxReady", 32'(txReady), 32'd1);
    checkOutput("rstTxDone", 32'(txDone), 32'd0);
    checkOutput("rstRxValid", 32'(rxValid), 32'd0);
    checkOutput("rstRxData", 32'(rxData), 32'd0);
    checkOutput("rstRxPe", 32'(rxParityErr), 32'd0);
    checkOutput("rstRxFe", 32'(rxFrameErr), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5 at baud_div 2, start bit exactly one bit period long
    runTxFrame(32'hA5, 1'b1);

    // 7 bits, odd parity, two stop bits through the line tie
    applyStimulus(2, 7, 1, 1, 1);
    runTxFrame(32'h55, 1'b0);

    // Even-parity character into a receiver configured for odd parity
    tieLoop = 1'b0;
    applyStimulus(2, 8, 1, 1, 0);
    driveRxFrame(32'h3C, 0, 0);

    // Broken stop bit, then a clean character once the line is back high
    applyStimulus(2, 8, 0, 0, 0);
    driveRxFrame(32'h96, 0, 1);
    driveRxFrame(32'h81, 0, 0);

    // Short low glitch must not produce a character; receiver still works afterwards
    rxBefore = rxCount;
    rxdDrv = 1'b0;
    repeat (3 * effDiv) @(negedge clk);
    rxdDrv = 1'b1;
    repeat (2 * OVS * effDiv) @(negedge clk);
    checkOutput("glitchNoRx", rxCount, rxBefore);
    driveRxFrame(32'h5A, 0, 0);

    // Reset in the middle of a TX data phase
    tieLoop = 1'b1;
    applyStimulus(2, 8, 0, 0, 0);
    doneBefore = txDoneCount;
    rxBefore = rxCount;
    @(negedge clk);
    txData = 8'h3E;
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
    repeat (4 * OVS * effDiv) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstTxd", 32'(txd), 32'd1);
    checkOutput("midRstReady", 32'(txReady), 32'd1);
    checkOutput("midRstDone", 32'(txDone), 32'd0);
    rst = 1'b0;
    repeat (12 * OVS * effDiv) @(negedge clk);
    checkOutput("midRstNoDone", txDoneCount, doneBefore);
    checkOutput("midRstNoRx", rxCount, rxBefore);
    runTxFrame(32'hC7, 1'b0);

    // Divisor of zero runs at one tick per clock
    applyStimulus(0, 8, 1, 0, 0);
    runTxFrame(32'h3B, 1'b0);

    // Randomized TX frames looped back into RX, with out-of-range lengths
    for (int n = 0; n < 10; n++) begin
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1));
      runTxFrame($urandom_range(0, 255), 1'b0);
    end

    // Randomized RX frames with occasional wrong parity or broken stop bits
    tieLoop = 1'b0;
    for (int n = 0; n < 10; n++) begin
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1));
      driveRxFrame($urandom_range(0, 255), $urandom_range(0, 1),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

`ifdef UART_LOOPBACK_EN
    // Internal loopback: pin stays idle, rxd pin ignored, RX sees the TX character
    applyStimulus(2, 8, 0, 0, 0);
    loopback = 1'b1;
    rxdDrv = 1'b0;
    rxBefore = rxCount;
    @(negedge clk);
    txData = 8'hC3;
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
    lows = 0;
    for (int i = 0; i < 12 * OVS * effDiv; i++) begin
      if (txd == 1'b0) lows++;
      @(negedge clk);
    end
    checkOutput("lbTxdIdle", lows, 0);
    checkOutput("lbRxCount", rxCount, rxBefore + 1);
    checkOutput("lbRxData", 32'(rxLastData), 32'hC3);
    loopback = 1'b0;
    rxdDrv = 1'b1;
    repeat (4) @(negedge clk);
`else
    lows = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised single-clock UART transceiver. It replaces the derived-clock TX/RX pair with clock-enable baud ticks, a 16x-oversampling receiver, ready/valid framing and separate error flags. Character length (5..DATA_W), parity and 1/2 stop bits are runtime-configurable. It sits between a register/bus front end and the board-level txd/rxd pins.

Parameters:
DATA_W, 8, maximum character length in bits; width of tx_data/rx_data
OVS, 16, oversample ticks per bit; even, >=4
DIV_W, 16, width of baud_div

Ports:
clk  in  1  system clock
rst  in  1  reset
baud_div  in  DIV_W  clk cycles per oversample tick; 0 treated as 1
length  in  4  character length; clamped to [5, DATA_W]
parity_en  in  1  1 = parity bit present
parity_type  in  1  0 = even, 1 = odd
stop2  in  1  1 = two stop bits
tx_valid  in  1  TX character offered
tx_ready  out  1  TX can accept (idle)
tx_data  in  DATA_W  character, LSB sent first
tx_done  out  1  1-cycle pulse at end of last stop bit
txd  out  1  serial out, idle high
rxd  in  1  serial in, asynchronous
rx_valid  out  1  1-cycle pulse, character received
rx_data  out  DATA_W  received character, bits >= length are zero
rx_parity_err  out  1  valid with rx_valid
rx_frame_err  out  1  valid with rx_valid; a stop bit sampled low

Behaviour:
- Reset: one clock (clk); rst is synchronous, active-high. Reset values: txd=1, tx_ready=1, tx_done=0, rx_valid=0, rx_data=0, both error flags=0, synchroniser flops=1, all FSMs IDLE, tick counter 0. Reset mid-frame aborts immediately with no partial pulses.
- Tick: counter runs whenever rst=0 and counts 0..max(baud_div,1)-1. tick=1 for one clk on wrap. One bit period = OVS ticks. TX and RX share the tick.
- Config (length, parity_*, stop2) is latched on TX accept and on RX start detect. Changes mid-frame have no effect on that frame.
- Parity bit = XOR(data[len-1:0]) XOR parity_type.
- TX FSM: IDLE -> START -> DATA (len bits) -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
  - Accept when tx_valid & tx_ready: latch data, tx_ready falls next cycle.
  - START begins at the first tick after accept. Each state lasts OVS ticks.
  - tx_done pulses on the clk that STOP completes. tx_ready=1 the same cycle, so back-to-back frames can follow.
  - tx_valid held during IDLE with tx_ready=1 is accepted in that cycle.
- RX path: rxd passes through a 2-flop synchroniser.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
  - IDLE: on a tick with sync rxd=0, enter START and clear the tick count.
  - START: at OVS/2 ticks, resample. If 1 (glitch), return to IDLE with no pulse. Otherwise move to DATA.
  - Each later bit is sampled every OVS ticks (mid-bit). Data shifts in LSB first.
  - Frame error if any stop sample = 0. Parity error if parity_en and received parity mismatches.
  - rx_valid pulses 1 clk after the final stop sample. rx_data and flags hold until the next pulse.
  - After a frame error the FSM still returns to IDLE and waits for rxd=1 before re-arming (break is not re-detected).
  - No backpressure: a new character overwrites rx_data.
- TX and RX are fully independent and can be active simultaneously.

Optional Feature:
UART_LOOPBACK_EN
- Defined: adds input port loopback (1 bit). When loopback=1, the RX synchroniser input is the internal TX serial signal, txd is forced to 1 and rxd is ignored.
- Undefined: the port does not exist; RX always samples rxd.
- Switching loopback mid-frame is undefined and is not tested.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t and rx_state_t enums (IDLE, START, DATA, PARITY, STOP1, STOP2)
  - parity constants PAR_EVEN=0, PAR_ODD=1
  - MIN_LEN=5
  - a clamp_len function
- Sub-module uart_baud_tick (clk, rst, baud_div -> tick). TX and RX FSMs stay inline in uart_core_param.

Test Plan:
- baud_div=2, 8N1, send 0xA5 -> txd low for 32 clk, then bits 1,0,1,0,0,1,0,1 at 32 clk each, stop high. tx_done pulses 320 clk after START begins.
- Loopback (or txd tied to rxd), 7 bits, odd parity, stop2, send 0x55 -> rx_valid once, rx_data=0x55, parity_err=0, frame_err=0. Frame is 11 bits.
- Drive rxd with even-parity 0x3C while configured odd -> rx_valid with rx_data=0x3C, rx_parity_err=1.
- Drive 8N1 frame with stop bit 0 -> rx_frame_err=1. Next valid frame 0x81 received cleanly once rxd has returned high.
- 3-tick low glitch on rxd (OVS=16) -> no rx_valid, RX back in IDLE.
- Assert rst mid-DATA of a TX frame -> next clk txd=1, tx_ready=1, no tx_done. A new tx_valid then starts a clean frame.
